// File: rtl/sprite_rom_arbiter_if.sv
// Bundle of the sprite fetch request side, the shared ROM port and the tagged read return.
// The arbiter connects through the slave modport; fetch units and the ROM model use master.
interface sprite_rom_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 12,
    parameter int ID_W    = 3
);
    logic                      en;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rom_address;
    logic [DATA_W-1:0]         rom_q;
    logic                      rd_valid;
    logic [ID_W-1:0]           rd_id;
    logic [DATA_W-1:0]         rd_data;

    modport master (
        output en, req, req_addr, rom_q,
        input  gnt, rom_address, rd_valid, rd_id, rd_data
    );

    modport slave (
        input  en, req, req_addr, rom_q,
        output gnt, rom_address, rd_valid, rd_id, rd_data
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM port among NUM_REQ fetch units.
// Each grant launches a tag that follows the ROM latency so rd_data returns with its owner ID.
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 12,
    parameter int ROM_LAT = 1,
    parameter int ID_W    = 3
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    sprite_rom_arbiter_if.slave  bus
);
    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_W-1:0]   r_ptr;
    logic [ADDR_W-1:0] r_rom_address;
    logic [ROM_LAT:0]  r_tag_vld;
    logic [ID_W-1:0]   r_tag_id [0:ROM_LAT];

    int                w_idx;
    logic              w_found;
    logic [ID_W-1:0]   w_winner;
    logic              w_grant;
    logic [ID_W-1:0]   w_ptr_next;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ADDR_W-1:0] w_sel_addr;

    // Walk the requesters starting at the pointer; wrap is explicit so non power-of-two
    // counts never produce an ID at or above NUM_REQ.
    always_comb begin
        w_idx    = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && bus.req[SEL_W'(w_idx)]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(w_idx);
            end
        end
    end

    assign w_grant    = bus.en && reset_n && w_found;
    assign w_ptr_next = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + ID_W'(1);

    always_comb begin
        w_gnt = '0;
        if (w_grant) begin
            w_gnt[SEL_W'(w_winner)] = 1'b1;
        end
    end

    always_comb begin
        w_sel_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_winner == ID_W'(k)) begin
                w_sel_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr         <= '0;
            r_rom_address <= '0;
            r_tag_vld     <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            if (w_grant) begin
                r_ptr         <= w_ptr_next;
                r_rom_address <= w_sel_addr;
            end
            // Stage 0 lines up with rom_address; the head lines up with rom_q.
            r_tag_vld   <= {r_tag_vld[ROM_LAT-1:0], w_grant};
            r_tag_id[0] <= w_grant ? w_winner : '0;
            for (int i = 1; i <= ROM_LAT; i++) begin
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    assign bus.gnt         = w_gnt;
    assign bus.rom_address = r_rom_address;
    assign bus.rd_valid    = r_tag_vld[ROM_LAT];
    assign bus.rd_id       = r_tag_id[ROM_LAT];
    assign bus.rd_data     = bus.rom_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: a 4-requester/1-cycle ROM build under a scoreboard monitor
// plus scenario tasks, and a 3-requester/3-cycle ROM build with its own scoreboard.
module tb_sprite_rom_arbiter;
    typedef struct {
        int         due;
        logic [2:0] id;
        logic [11:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    sprite_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(13), .DATA_W(12), .ID_W(3)) bus_a ();
    sprite_rom_arbiter_if #(.NUM_REQ(3), .ADDR_W(13), .DATA_W(12), .ID_W(2)) bus_b ();

    sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(13), .DATA_W(12), .ROM_LAT(1), .ID_W(3)) dut_a (
        .vga_clk (clk),
        .reset_n (rst_a_n),
        .bus     (bus_a.slave)
    );

    sprite_rom_arbiter #(.NUM_REQ(3), .ADDR_W(13), .DATA_W(12), .ROM_LAT(3), .ID_W(2)) dut_b (
        .vga_clk (clk),
        .reset_n (rst_b_n),
        .bus     (bus_b.slave)
    );

    function automatic logic [11:0] rom_fn(input logic [12:0] a);
        return a[11:0] ^ 12'h5A3 ^ {a[12], 11'b0};
    endfunction

    // Model ROMs: one register for the 1-cycle build, three for the 3-cycle build.
    logic [11:0] rom_a_q;
    logic [11:0] rom_b_p0, rom_b_p1, rom_b_p2;
    always @(posedge clk) begin
        rom_a_q  <= rom_fn(bus_a.rom_address);
        rom_b_p0 <= rom_fn(bus_b.rom_address);
        rom_b_p1 <= rom_b_p0;
        rom_b_p2 <= rom_b_p1;
    end
    assign bus_a.rom_q = rom_a_q;
    assign bus_b.rom_q = rom_b_p2;

    exp_t       sb_a[$];
    int         m_ptr   = 0;
    logic [12:0] m_raddr = '0;

    // Continuous reference model for build A: expected grant, address and tagged returns.
    always @(negedge clk) begin : mon_a
        logic [3:0]  eg;
        int          win;
        int          idx;
        logic [12:0] wa;
        exp_t        e;
        cyc++;
        if (rst_a_n !== 1'b1) begin
            sb_a.delete();
            m_ptr   = 0;
            m_raddr = '0;
            n_checks++;
            if (bus_a.gnt !== 4'b0 || bus_a.rd_valid !== 1'b0 || bus_a.rom_address !== 13'h0) begin
                n_fail++;
                $display("FAIL mon_in_reset: gnt=%b rd_valid=%b rom_address=%h, required 0/0/0",
                         bus_a.gnt, bus_a.rd_valid, bus_a.rom_address);
            end
        end else begin
            win = -1;
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (win < 0 && bus_a.en === 1'b1 && bus_a.req[idx] === 1'b1) win = idx;
            end
            eg = (win >= 0) ? (4'b0001 << win) : 4'b0000;
            n_checks++;
            if (bus_a.gnt !== eg) begin
                n_fail++;
                $display("FAIL mon_gnt: got %b required %b (cyc %0d)", bus_a.gnt, eg, cyc);
            end
            n_checks++;
            if (bus_a.rom_address !== m_raddr) begin
                n_fail++;
                $display("FAIL mon_rom_address: got %h required %h (cyc %0d)", bus_a.rom_address, m_raddr, cyc);
            end
            if (sb_a.size() > 0 && sb_a[0].due == cyc) begin
                e = sb_a.pop_front();
                n_checks++;
                if (bus_a.rd_valid !== 1'b1 || bus_a.rd_id !== e.id || bus_a.rd_data !== e.data) begin
                    n_fail++;
                    $display("FAIL mon_read: got v=%b id=%0d data=%h required v=1 id=%0d data=%h (cyc %0d)",
                             bus_a.rd_valid, bus_a.rd_id, bus_a.rd_data, e.id, e.data, cyc);
                end
            end else begin
                n_checks++;
                if (bus_a.rd_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mon_idle: got rd_valid=%b required 0 (cyc %0d)", bus_a.rd_valid, cyc);
                end
            end
            if (win >= 0) begin
                wa = bus_a.req_addr[win*13 +: 13];
                e.due  = cyc + 2;
                e.id   = 3'(win);
                e.data = rom_fn(wa);
                sb_a.push_back(e);
                m_raddr = wa;
                m_ptr   = (win + 1) % 4;
            end
        end
    end

    task automatic restart_a(input logic [3:0] r);
        @(posedge clk); #1;
        rst_a_n   = 1'b0;
        bus_a.en  = 1'b1;
        bus_a.req = r;
        bus_a.req_addr = {13'h040, 13'h030, 13'h020, 13'h010};
        @(posedge clk); #1;
        rst_a_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_a_n   = 1'b0;
        bus_a.en  = 1'b1;
        bus_a.req = 4'b1111;
        bus_a.req_addr = {13'h040, 13'h030, 13'h020, 13'h010};
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus_a.gnt !== 4'b0000 || bus_a.rd_valid !== 1'b0 || bus_a.rom_address !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_hold: gnt=%b rd_valid=%b rom_address=%h, required 0000/0/0",
                     bus_a.gnt, bus_a.rd_valid, bus_a.rom_address);
        end
        @(posedge clk); #1;
        rst_a_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_a.gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_gnt: got %b required 0001", bus_a.gnt);
        end
        @(negedge clk);
        n_checks++;
        if (bus_a.rom_address !== 13'h010) begin
            n_fail++;
            $display("FAIL reset_first_addr: got %h required 010", bus_a.rom_address);
        end
        @(negedge clk);
        n_checks++;
        if (bus_a.rd_valid !== 1'b1 || bus_a.rd_id !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_first_read: got v=%b id=%0d required v=1 id=0", bus_a.rd_valid, bus_a.rd_id);
        end
    endtask

    task automatic test_rotation();
        logic [3:0]  eg;
        logic [12:0] ea;
        restart_a(4'b1111);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            eg = 4'b0001 << (i % 4);
            n_checks++;
            if (bus_a.gnt !== eg) begin
                n_fail++;
                $display("FAIL rotation_gnt[%0d]: got %b required %b", i, bus_a.gnt, eg);
            end
            if (i >= 1) begin
                ea = 13'((((i - 1) % 4) + 1) * 16);
                n_checks++;
                if (bus_a.rom_address !== ea) begin
                    n_fail++;
                    $display("FAIL rotation_addr[%0d]: got %h required %h", i, bus_a.rom_address, ea);
                end
            end
            if (i >= 2) begin
                n_checks++;
                if (bus_a.rd_valid !== 1'b1 || bus_a.rd_id !== 3'((i - 2) % 4)) begin
                    n_fail++;
                    $display("FAIL rotation_read[%0d]: got v=%b id=%0d required v=1 id=%0d",
                             i, bus_a.rd_valid, bus_a.rd_id, (i - 2) % 4);
                end
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] eg;
        restart_a(4'b0001);
        @(negedge clk);
        @(posedge clk); #1;
        bus_a.req = 4'b1001;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            eg = (i % 2 == 0) ? 4'b1000 : 4'b0001;
            n_checks++;
            if (bus_a.gnt !== eg) begin
                n_fail++;
                $display("FAIL fairness_gnt[%0d]: got %b required %b", i, bus_a.gnt, eg);
            end
        end
    endtask

    task automatic test_en_gating();
        restart_a(4'b1111);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        bus_a.en  = 1'b0;
        bus_a.req = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus_a.gnt !== 4'b0000 || bus_a.rom_address !== 13'h020) begin
                n_fail++;
                $display("FAIL en_hold[%0d]: gnt=%b rom_address=%h required 0000/020", i, bus_a.gnt, bus_a.rom_address);
            end
            n_checks++;
            if (bus_a.rd_valid !== (i < 2) || (i < 2 && bus_a.rd_id !== 3'(i))) begin
                n_fail++;
                $display("FAIL en_drain[%0d]: got v=%b id=%0d required v=%0d id=%0d",
                         i, bus_a.rd_valid, bus_a.rd_id, (i < 2), i);
            end
        end
        @(posedge clk); #1;
        bus_a.en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_a.gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL en_restore_gnt: got %b required 0010", bus_a.gnt);
        end
    endtask

    task automatic test_reset_mid();
        restart_a(4'b1111);
        @(negedge clk);
        @(posedge clk); #1;
        rst_a_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus_a.rd_valid !== 1'b0 || bus_a.rom_address !== 13'h0 || bus_a.gnt !== 4'b0) begin
                n_fail++;
                $display("FAIL midreset_hold[%0d]: v=%b rom_address=%h gnt=%b required 0/0/0",
                         i, bus_a.rd_valid, bus_a.rom_address, bus_a.gnt);
            end
        end
        @(posedge clk); #1;
        rst_a_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_a.gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL midreset_ptr: got %b required 0001", bus_a.gnt);
        end
        @(negedge clk);
        n_checks++;
        if (bus_a.rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_early: got rd_valid=%b required 0", bus_a.rd_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus_a.rd_valid !== 1'b1 || bus_a.rd_id !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_first: got v=%b id=%0d required v=1 id=0", bus_a.rd_valid, bus_a.rd_id);
        end
    endtask

    task automatic test_back_to_back();
        restart_a(4'b0100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus_a.gnt !== 4'b0100 || (i >= 2 && (bus_a.rd_valid !== 1'b1 || bus_a.rd_id !== 3'd2))) begin
                n_fail++;
                $display("FAIL b2b[%0d]: gnt=%b v=%b id=%0d required 0100/1/2",
                         i, bus_a.gnt, bus_a.rd_valid, bus_a.rd_id);
            end
            @(posedge clk); #1;
            bus_a.req_addr[38:26] = 13'($urandom());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            rst_a_n        = ($urandom_range(0, 49) != 0);
            bus_a.en       = ($urandom_range(0, 4) != 0);
            bus_a.req      = 4'($urandom());
            bus_a.req_addr = 52'({$urandom(), $urandom()});
        end
        @(posedge clk); #1;
        rst_a_n = 1'b1;
    endtask

    task automatic test_drain();
        @(posedge clk); #1;
        bus_a.en  = 1'b1;
        bus_a.req = 4'b0000;
        repeat (6) @(negedge clk);
        n_checks++;
        if (sb_a.size() != 0) begin
            n_fail++;
            $display("FAIL drain_a: %0d reads outstanding, required 0", sb_a.size());
        end
    endtask

    task automatic test_lat3_req3();
        exp_t        sb_b[$];
        exp_t        e;
        logic [2:0]  eg;
        logic [12:0] addr_tbl [3];
        addr_tbl[0] = 13'h0A1;
        addr_tbl[1] = 13'h0B2;
        addr_tbl[2] = 13'h1C3;
        @(posedge clk); #1;
        rst_b_n        = 1'b0;
        bus_b.en       = 1'b1;
        bus_b.req      = 3'b111;
        bus_b.req_addr = {addr_tbl[2], addr_tbl[1], addr_tbl[0]};
        @(posedge clk); #1;
        rst_b_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            eg = (i < 8) ? (3'b001 << (i % 3)) : 3'b000;
            n_checks++;
            if (bus_b.gnt !== eg) begin
                n_fail++;
                $display("FAIL lat3_gnt[%0d]: got %b required %b", i, bus_b.gnt, eg);
            end
            if (sb_b.size() > 0 && sb_b[0].due == i) begin
                e = sb_b.pop_front();
                n_checks++;
                if (bus_b.rd_valid !== 1'b1 || {1'b0, bus_b.rd_id} !== e.id || bus_b.rd_data !== e.data) begin
                    n_fail++;
                    $display("FAIL lat3_read[%0d]: got v=%b id=%0d data=%h required v=1 id=%0d data=%h",
                             i, bus_b.rd_valid, bus_b.rd_id, bus_b.rd_data, e.id, e.data);
                end
            end else begin
                n_checks++;
                if (bus_b.rd_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lat3_idle[%0d]: got rd_valid=%b id=%0d required 0", i, bus_b.rd_valid, bus_b.rd_id);
                end
            end
            if (i < 8) begin
                e.due  = i + 4;
                e.id   = 3'(i % 3);
                e.data = rom_fn(addr_tbl[i % 3]);
                sb_b.push_back(e);
            end
            if (i == 7) begin
                @(posedge clk); #1;
                bus_b.req = 3'b000;
            end
        end
        n_checks++;
        if (sb_b.size() != 0) begin
            n_fail++;
            $display("FAIL lat3_drain: %0d reads outstanding, required 0", sb_b.size());
        end
    endtask

    initial begin
        rst_a_n        = 1'b1;
        rst_b_n        = 1'b1;
        bus_a.en       = 1'b0;
        bus_a.req      = '0;
        bus_a.req_addr = '0;
        bus_b.en       = 1'b0;
        bus_b.req      = '0;
        bus_b.req_addr = '0;
        #1;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        test_reset();
        test_rotation();
        test_fairness();
        test_en_gating();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_drain();
        test_lat3_req3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one synchronous sprite ROM read port among up to NUM_REQ sprite fetch units (Mario, DK, barrels, background) in the VGA pixel domain. Each cycle it grants at most one requester with round-robin fairness and drives that requester's address to the ROM. It tags the read so the returned palette index is delivered with the winning requester's ID after the fixed ROM latency. It sits between the per-sprite address generators and the shared ROM/palette pair, ahead of the pixel mux.

## Interface

Parameters:
- NUM_REQ, 4: number of requesters; 2..8.
- ADDR_W, 13: ROM address width.
- DATA_W, 12: ROM data (palette index) width.
- ROM_LAT, 1: cycles from a rom_address change to valid rom_q; 1..3.
- ID_W, 3: requester ID width; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- vga_clk  in  1  pixel clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  grant enable; low blocks new grants, in-flight reads still complete.
- req  in  NUM_REQ  per-requester read request, level.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot grant, combinational in the request cycle.
- rom_address  out  ADDR_W  registered address to the ROM.
- rom_q  in  DATA_W  ROM read data.
- rd_valid  out  1  rd_data is valid this cycle, registered.
- rd_id  out  ID_W  requester that owns rd_data, registered.
- rd_data  out  DATA_W  equals rom_q, passed through combinationally.

## Operation

- Round-robin pointer ptr (ID_W bits) marks the highest-priority requester.
- Search order is ptr, ptr+1, …, wrapping modulo NUM_REQ.
- Grant condition: en=1 and reset_n=1 and req≠0. The first set req bit in search order wins, and gnt has exactly that bit set.
- Otherwise gnt=0.
- On a granted cycle, at the next posedge:
  - rom_address <= req_addr[winner].
  - ptr <= (winner+1) mod NUM_REQ.
  - A tag {1, winner} enters the ROM_LAT+1 stage tag pipeline.
- On a non-granted cycle:
  - rom_address holds its value.
  - ptr holds.
  - A tag {0, 0} enters the pipeline.
- The pipeline head drives rd_valid and rd_id.
- A requester keeps req high as long as it wants reads. Each grant is one read, and back-to-back grants to the same requester are legal only when no other req is set.
- Requests are not queued. An ungranted requester simply retries with req still high.
- req_addr for a requester is sampled only in the cycle it is granted.
- en low mid-stream: no new tags enter, outstanding tags drain normally, and ptr is frozen.
- NUM_REQ not a power of two: pointer wrap is explicit at NUM_REQ-1 → 0, and IDs ≥ NUM_REQ are never produced.

## Timing

- Reset state (asynchronous, immediate):
  - ptr=0.
  - rom_address=0.
  - All tags cleared.
  - rd_valid=0, rd_id=0.
  - gnt=0 while reset_n=0.
- Latency: grant in cycle t → rom_address valid in t+1 → rd_valid=1, rd_id=winner, rd_data=rom_q in cycle t+1+ROM_LAT.
- Throughput: one read per cycle sustained. rd_valid is high in consecutive cycles for consecutive grants.
- Ordering: rd_id order equals grant order, and there are no reorders or drops.
- Simultaneous all-req: grants rotate 0,1,…,NUM_REQ-1,0,… with no requester starved longer than NUM_REQ-1 cycles.
- Reset asserted mid-operation: in-flight reads are discarded. The first read after release returns no earlier than 1+ROM_LAT cycles after the first post-reset grant.
- rd_data is meaningful only when rd_valid=1. Its value when rd_valid=0 is unspecified.

## Test plan

- **Reset and first grant:** hold reset_n=0 with req=4'b1111 → gnt=0, rd_valid=0, rom_address=0. Release reset_n → first grant is gnt=4'b0001, rom_address=req_addr[0] next cycle, and rd_valid=1 with rd_id=0 at grant+2 (ROM_LAT=1).
- **Rotation:** req=4'b1111 continuously with addresses 0x010/0x020/0x030/0x040 → gnt sequence 0001,0010,0100,1000,0001. rom_address follows 0x010,0x020,0x030,0x040, and rd_id follows 0,1,2,3 with rd_valid continuously high.
- **Fairness after skip:** ptr=1 with req=4'b1001 → grant requester 3, then 0, then 3. Requester 0 is never granted twice in a row while req[3]=1.
- **en gating:** 2 grants in flight, then en=0 for 5 cycles with req=4'b0010 → gnt=0, both pending reads return with rd_valid, then rd_valid=0, and ptr/rom_address are unchanged. Restoring en=1 grants requester 1 immediately.
- **Reset mid-stream:** assert reset_n=0 one cycle after a grant → rd_valid is never asserted for that read, and ptr and rom_address return to 0.
- **ROM_LAT=3 and NUM_REQ=3 build:** a model ROM with 3-cycle latency plus requests on all three → rd_id returns 0,1,2,0 at grant+4, and no ID 3 ever appears.
